// File: rtl/uart_top.sv
// UART with internal loopback: baud generator, 8-bit transmitter and 2-flop-synchronised receiver.
// Define UART_PARITY_EN to add the even-parity bit to the frame and enable parity_error.
module uart_top (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       TX_start,
    input  logic [7:0] TX_DATA,
    output logic [7:0] RX_dataout,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int unsigned DIV_W  = 9;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;

    localparam logic [DIV_W-1:0]  DIV_9600   = DIV_W'(326 - 1);
    localparam logic [DIV_W-1:0]  DIV_19200  = DIV_W'(163 - 1);
    localparam logic [DIV_W-1:0]  DIV_57600  = DIV_W'(54 - 1);
    localparam logic [DIV_W-1:0]  DIV_115200 = DIV_W'(27 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(15);
    localparam logic [TICK_W-1:0] TICK_MID   = TICK_W'(7);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    // ---------------------------------------------------------------
    // Baud generator: down-counter reloads (and re-reads sel) only at zero
    // ---------------------------------------------------------------
    logic [DIV_W-1:0] baud_cnt_q;
    logic [DIV_W-1:0] baud_cnt_d;
    logic [DIV_W-1:0] baud_load_c;
    logic             tick16_c;

    always_comb begin
        case (sel)
            2'b00:   baud_load_c = DIV_9600;
            2'b01:   baud_load_c = DIV_19200;
            2'b10:   baud_load_c = DIV_57600;
            default: baud_load_c = DIV_115200;
        endcase
        tick16_c   = (baud_cnt_q == '0);
        baud_cnt_d = tick16_c ? baud_load_c : baud_cnt_q - DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) baud_cnt_q <= '0;
        else        baud_cnt_q <= baud_cnt_d;
    end

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------
    state_e            tx_state_q, tx_state_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [TICK_W-1:0] tx_tick_q,  tx_tick_d;
    logic [BIT_W-1:0]  tx_bit_q,   tx_bit_d;
    logic              tx_q,       tx_d;
`ifdef UART_PARITY_EN
    logic              tx_par_q,   tx_par_d;
`endif
    logic              tx_line;

    assign tx_line = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tick16_c) begin
            tx_tick_d = tx_tick_q + TICK_W'(1);
            case (tx_state_q)
                ST_IDLE: begin
                    tx_tick_d = '0;
                    if (TX_start) begin
                        tx_state_d = ST_START;
                        tx_shift_d = TX_DATA;
                        tx_bit_d   = '0;
`ifdef UART_PARITY_EN
                        tx_par_d   = ^TX_DATA;
`endif
                    end
                end
                ST_START: begin
                    if (tx_tick_q == TICK_LAST) tx_state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (tx_tick_q == TICK_LAST) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state_d = ST_PARITY;
`else
                            tx_state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tx_tick_q == TICK_LAST) tx_state_d = ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (tx_tick_q == TICK_LAST) tx_state_d = ST_IDLE;
                end
                default: tx_state_d = ST_IDLE;
            endcase
        end

        // Line level follows the state being entered so it is registered with it
        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = tx_par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    logic              rx_s1_q, rx_s2_q;
    state_e            rx_state_q, rx_state_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [TICK_W-1:0] rx_tick_q,  rx_tick_d;
    logic [BIT_W-1:0]  rx_bit_q,   rx_bit_d;
    logic [7:0]        rx_dout_q,  rx_dout_d;
    logic              rx_se_q,    rx_se_d;
`ifdef UART_PARITY_EN
    logic              rx_par_q,   rx_par_d;
    logic              rx_pe_q,    rx_pe_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= tx_line;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_dout_d  = rx_dout_q;
        rx_se_d    = rx_se_q;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
        rx_pe_d    = rx_pe_q;
`endif
        if (tick16_c) begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
            case (rx_state_q)
                ST_IDLE: begin
                    rx_tick_d = '0;
                    if (!rx_s2_q) begin
                        rx_state_d = ST_START;
                        rx_bit_d   = '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit confirmation rejects short glitches
                    if (rx_tick_q == TICK_MID) begin
                        rx_tick_d  = '0;
                        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + BIT_W'(1);
                        if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state_d = ST_PARITY;
`else
                            rx_state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_par_d   = rx_s2_q;
                        rx_state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_dout_d  = rx_shift_q;
                        rx_se_d    = ~rx_s2_q;
`ifdef UART_PARITY_EN
                        rx_pe_d    = rx_par_q ^ (^rx_shift_q);
`endif
                        rx_state_d = ST_IDLE;
                    end
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_dout_q  <= '0;
            rx_se_q    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_pe_q    <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_dout_q  <= rx_dout_d;
            rx_se_q    <= rx_se_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
            rx_pe_q    <= rx_pe_d;
`endif
        end
    end

    assign RX_dataout = rx_dout_q;
    assign stop_error = rx_se_q;
`ifdef UART_PARITY_EN
    assign parity_error = rx_pe_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_top.sv
// Directed loopback bench for uart_top: expected bytes are queued at transmit and checked at frame end.
module tb_uart_top;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] sel = 2'b10;
    logic       TX_start = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic [7:0] RX_dataout;
    logic       parity_error;
    logic       stop_error;

`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] b2b [4] = '{8'h01, 8'hFF, 8'h01, 8'hFF};

    always #10 clk = ~clk;

    uart_top dut (
        .clk          (clk),
        .reset        (reset),
        .sel          (sel),
        .TX_start     (TX_start),
        .TX_DATA      (TX_DATA),
        .RX_dataout   (RX_dataout),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int bitp();
        case (sel)
            2'b00:   return 16 * 326;
            2'b01:   return 16 * 163;
            2'b10:   return 16 * 54;
            default: return 16 * 27;
        endcase
    endfunction

    // Bounded wait for a high-to-low transition on the loopback line
    task automatic wait_start(input int budget);
        bit   seen = 1'b0;
        logic prev = dut.tx_line;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && dut.tx_line === 1'b0) seen = 1'b1;
            prev = dut.tx_line;
        end
        chk("frame_start", 8'(seen), 8'd1);
    endtask

    task automatic check_rx(input string tag, input logic exp_pe, input logic exp_se);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s_rx", tag), RX_dataout, e);
            chk($sformatf("%s_pe", tag), 8'(parity_error), 8'(exp_pe));
            chk($sformatf("%s_se", tag), 8'(stop_error), 8'(exp_se));
        end
    endtask

    // corrupt: 0 = clean, 1 = invert parity bit, 2 = force stop bit low
    task automatic run_frame(input string tag, input logic [7:0] d, input int corrupt,
                             input logic exp_pe, input logic exp_se);
        int bp;
        int t;
        bp = bitp();
        t  = 0;
        wait_clks(bp);
        TX_DATA  = d;
        TX_start = 1'b1;
        exp_q.push_back(d);
        wait_start(2 * bp);
        TX_start = 1'b0;
        TX_DATA  = ~d;
        if (corrupt == 2) begin
            wait_clks((FB - 1) * bp + bp / 2 - 3 * (bp / 16));
            force dut.tx_line = 1'b0;
            wait_clks(6 * (bp / 16));
            release dut.tx_line;
            t = (FB - 1) * bp + bp / 2 + 3 * (bp / 16);
        end
`ifdef UART_PARITY_EN
        if (corrupt == 1) begin
            wait_clks(9 * bp + bp / 2 - 3 * (bp / 16));
            if (^d) force dut.tx_line = 1'b0;
            else    force dut.tx_line = 1'b1;
            wait_clks(6 * (bp / 16));
            release dut.tx_line;
            t = 9 * bp + bp / 2 + 3 * (bp / 16);
        end
`endif
        wait_clks(FB * bp - 4 - t);
        check_rx(tag, exp_pe, exp_se);
    endtask

    initial begin
        bit found;
        int bp;

        // Reset state
        wait_clks(5);
        chk("reset_rx", RX_dataout, 8'h00);
        chk("reset_pe", 8'(parity_error), 8'd0);
        chk("reset_se", 8'(stop_error), 8'd0);
        chk("reset_line", 8'(dut.tx_line), 8'd1);

        // First frame straight out of reset at 57600
        TX_DATA  = 8'hAA;
        TX_start = 1'b1;
        exp_q.push_back(8'hAA);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 11 * 16 * 54 + 40 && !found; i++) begin
            @(negedge clk);
            if (dut.tx_line === 1'b0) TX_start = 1'b0;
            if (RX_dataout === 8'hAA) found = 1'b1;
        end
        chk("first_latency", 8'(found), 8'd1);
        check_rx("first", 1'b0, 1'b0);
        wait_clks(bitp());

        // Back-to-back frames at 115200 with TX_DATA changed mid-frame
        sel = 2'b11;
        wait_clks(200);
        bp = bitp();
        TX_DATA = b2b[0];
        exp_q.push_back(b2b[0]);
        TX_start = 1'b1;
        wait_start(2 * bp);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                TX_DATA = b2b[i + 1];
                exp_q.push_back(b2b[i + 1]);
            end else begin
                TX_start = 1'b0;
            end
`ifdef UART_PARITY_EN
            wait_clks(9 * bp + bp / 2);
            chk($sformatf("b2b%0d_parbit", i), 8'(dut.tx_line), 8'(^b2b[i]));
            wait_clks(FB * bp - 4 - (9 * bp + bp / 2));
`else
            wait_clks(FB * bp - 4);
`endif
            check_rx($sformatf("b2b%0d", i), 1'b0, 1'b0);
            if (i < 3) wait_start(2 * (bp / 16) + 8);
        end

`ifdef UART_PARITY_EN
        run_frame("par_err", 8'h3C, 1, 1'b1, 1'b0);
        run_frame("par_clean", 8'h3C, 0, 1'b0, 1'b0);
`endif

        // Stop-bit error and recovery at 57600
        sel = 2'b10;
        wait_clks(200);
        run_frame("stop_err", 8'h55, 2, 1'b0, 1'b1);
        run_frame("stop_clean", 8'h55, 0, 1'b0, 1'b0);

        // One-tick low glitch on an idle line at 115200
        sel = 2'b11;
        wait_clks(200 + bitp());
        force dut.tx_line = 1'b0;
        wait_clks(27);
        release dut.tx_line;
        wait_clks(12 * bitp());
        chk("glitch_rx", RX_dataout, 8'h55);
        chk("glitch_pe", 8'(parity_error), 8'd0);
        chk("glitch_se", 8'(stop_error), 8'd0);

        // Reset in the middle of a frame
        TX_DATA  = 8'h81;
        TX_start = 1'b1;
        wait_start(2 * bitp());
        TX_start = 1'b0;
        wait_clks(5 * bitp());
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_rx", RX_dataout, 8'h00);
        chk("midrst_pe", 8'(parity_error), 8'd0);
        chk("midrst_se", 8'(stop_error), 8'd0);
        chk("midrst_line", 8'(dut.tx_line), 8'd1);
        wait_clks(5);
        reset = 1'b1;
        wait_clks(FB * bitp() + 100);
        chk("post_abort_rx", RX_dataout, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
